multicycle_sequencer: RTL

- Control FSM that sequences the RV32 datapath over several cycles instead of one, so instruction and data memories can take variable latency.
- Handles the existing subset: addi, lw, lb, sw, sb.
- Drives PC/IR load, register-file write, data-memory write type, immediate select and write-back select.
- Adds an instruction-retire counter, halt control and a bus watchdog that faults on a missing memory acknowledge.

---
 rtl/multicycle_sequencer_pkg.sv | 54 +++++
 rtl/multicycle_sequencer_bus_watchdog.sv | 28 ++
 rtl/multicycle_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: states, opcode fields,
// data-memory write codes and the decoded instruction class.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;

  localparam logic [1:0] WE_RD   = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_WORD = 2'b10;

  typedef enum logic [2:0] {
    C_ADDI = 3'd0,
    C_LW   = 3'd1,
    C_LB   = 3'd2,
    C_SW   = 3'd3,
    C_SB   = 3'd4
  } iclass_e;

  typedef struct packed {
    logic    ok;
    iclass_e cls;
  } dec_t;

  // Anything outside the five supported encodings comes back with ok=0.
  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3);
    dec_t d;
    d.ok  = 1'b1;
    d.cls = C_ADDI;
    if (op == OP_IMM && f3 == F3_ADDI)         d.cls = C_ADDI;
    else if (op == OP_LOAD && f3 == F3_WORD)   d.cls = C_LW;
    else if (op == OP_LOAD && f3 == F3_BYTE)   d.cls = C_LB;
    else if (op == OP_STORE && f3 == F3_WORD)  d.cls = C_SW;
    else if (op == OP_STORE && f3 == F3_BYTE)  d.cls = C_SB;
    else                                       d.ok  = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_bus_watchdog.sv
// Counts unacknowledged request cycles; expired flags the cycle on which the
// limit is reached with the ack still low.
module bus_watchdog #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count_en,
  input  logic ack,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   cnt_q <= '0;
    else if (clear)            cnt_q <= '0;
    else if (count_en && !ack) cnt_q <= cnt_q + CNT_W'(1);
  end

  // An ack arriving on the limit cycle wins over the fault.
  assign expired = count_en && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32 addi/lw/lb/sw/sb datapath with
// variable-latency memories, retire counter, halt and bus watchdog.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        dmem_req,
  output logic [1:0]  dmem_we,
  output logic        reg_we,
  output logic        imm_sel,
  output logic        wb_sel,
  output logic        load_byte,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  iclass_e     cls_q;
  logic        illegal_q, timeout_q;
  logic [31:0] cnt_q;
  dec_t        dec;
  logic        in_fetch, in_mem, is_load, is_store, retire;
  logic        wd_clear, wd_ack, wd_expired;

  assign dec      = decode(opcode, funct3);
  assign in_fetch = (state_q == S_FETCH);
  assign in_mem   = (state_q == S_MEM);
  assign is_load  = (cls_q == C_LW) || (cls_q == C_LB);
  assign is_store = (cls_q == C_SW) || (cls_q == C_SB);
  assign retire   = (state_q == S_WB) || (in_mem && dmem_ack && is_store);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (imem_ack)        state_d = S_DECODE;
                else if (wd_expired) state_d = S_FAULT;
      S_DECODE: state_d = dec.ok ? S_EXEC : S_FAULT;
      S_EXEC:   state_d = (cls_q == C_ADDI) ? S_WB : S_MEM;
      S_MEM:    if (dmem_ack)        state_d = is_load ? S_WB : (halt_req ? S_HALT : S_FETCH);
                else if (wd_expired) state_d = S_FAULT;
      S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:   if (!halt_req)       state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ADDI;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        if (dec.ok) cls_q     <= dec.cls;
        else        illegal_q <= 1'b1;
      end
      if (wd_expired) timeout_q <= 1'b1;
      if (retire)     cnt_q     <= cnt_q + 32'd1;
    end
  end

  // One counter serves both buses; it restarts whenever a request phase begins.
  assign wd_clear = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
  assign wd_ack   = in_fetch ? imem_ack : dmem_ack;

  bus_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wd (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (wd_clear),
    .count_en (in_fetch || in_mem),
    .ack      (wd_ack),
    .expired  (wd_expired)
  );

  // Strobes are gated by RST so nothing fires while reset is held.
  assign imem_req  = !RST && in_fetch;
  assign ir_we     = !RST && in_fetch && imem_ack;
  assign pc_we     = !RST && in_fetch && imem_ack;
  assign dmem_req  = !RST && in_mem;
  assign dmem_we   = (!RST && in_mem) ? ((cls_q == C_SB) ? WE_BYTE :
                                         (cls_q == C_SW) ? WE_WORD : WE_RD) : WE_RD;
  assign reg_we    = !RST && (state_q == S_WB);
  assign imm_sel   = is_store;
  assign wb_sel    = is_load;
  assign load_byte = (cls_q == C_LB);

  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
